// File: rtl/jtag_pkg.sv
// rtl/jtag_pkg.sv - TAP state encoding and instruction opcode constants
// Opcodes that are not all-zeros/all-ones are given as small integers and
// sized to the IR width by the user; EXTEST and BYPASS are built with the
// '0 / '1 idioms at the point of use.
package jtag_pkg;

    // Conventional 1149.1 state encoding (4 bits, all 16 codes used).
    typedef enum logic [3:0] {
        TAP_EXIT2_DR  = 4'h0,
        TAP_EXIT1_DR  = 4'h1,
        TAP_SHIFT_DR  = 4'h2,
        TAP_PAUSE_DR  = 4'h3,
        TAP_SEL_IR    = 4'h4,
        TAP_UPD_DR    = 4'h5,
        TAP_CAP_DR    = 4'h6,
        TAP_SEL_DR    = 4'h7,
        TAP_EXIT2_IR  = 4'h8,
        TAP_EXIT1_IR  = 4'h9,
        TAP_SHIFT_IR  = 4'hA,
        TAP_PAUSE_IR  = 4'hB,
        TAP_RTI       = 4'hC,
        TAP_UPD_IR    = 4'hD,
        TAP_CAP_IR    = 4'hE,
        TAP_TLR       = 4'hF
    } tap_state_t;

    localparam int unsigned OP_SAMPLE = 1;
    localparam int unsigned OP_IDCODE = 2;
    localparam int unsigned ID_W      = 32;

endpackage

// File: rtl/jtag_tap_fsm.sv
// rtl/jtag_tap_fsm.sv - 16-state IEEE 1149.1 TAP controller state machine
// Ports:
//   tck     in   test clock, state advances on rising edge
//   trst_n  in   asynchronous active-low reset to Test-Logic-Reset
//   tms_i   in   test mode select
//   state_o out  current TAP state
module jtag_tap_fsm
    import jtag_pkg::*;
(
    input  logic       tck,
    input  logic       trst_n,
    input  logic       tms_i,
    output tap_state_t state_o
);

    tap_state_t state_q, state_d;

    always_ff @(posedge tck or negedge trst_n) begin
        if (!trst_n) begin
            state_q <= TAP_TLR;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            TAP_TLR:      state_d = tms_i ? TAP_TLR      : TAP_RTI;
            TAP_RTI:      state_d = tms_i ? TAP_SEL_DR   : TAP_RTI;
            TAP_SEL_DR:   state_d = tms_i ? TAP_SEL_IR   : TAP_CAP_DR;
            TAP_CAP_DR:   state_d = tms_i ? TAP_EXIT1_DR : TAP_SHIFT_DR;
            TAP_SHIFT_DR: state_d = tms_i ? TAP_EXIT1_DR : TAP_SHIFT_DR;
            TAP_EXIT1_DR: state_d = tms_i ? TAP_UPD_DR   : TAP_PAUSE_DR;
            TAP_PAUSE_DR: state_d = tms_i ? TAP_EXIT2_DR : TAP_PAUSE_DR;
            TAP_EXIT2_DR: state_d = tms_i ? TAP_UPD_DR   : TAP_SHIFT_DR;
            TAP_UPD_DR:   state_d = tms_i ? TAP_SEL_DR   : TAP_RTI;
            TAP_SEL_IR:   state_d = tms_i ? TAP_TLR      : TAP_CAP_IR;
            TAP_CAP_IR:   state_d = tms_i ? TAP_EXIT1_IR : TAP_SHIFT_IR;
            TAP_SHIFT_IR: state_d = tms_i ? TAP_EXIT1_IR : TAP_SHIFT_IR;
            TAP_EXIT1_IR: state_d = tms_i ? TAP_UPD_IR   : TAP_PAUSE_IR;
            TAP_PAUSE_IR: state_d = tms_i ? TAP_EXIT2_IR : TAP_PAUSE_IR;
            TAP_EXIT2_IR: state_d = tms_i ? TAP_UPD_IR   : TAP_SHIFT_IR;
            TAP_UPD_IR:   state_d = tms_i ? TAP_SEL_DR   : TAP_RTI;
            default:      state_d = TAP_TLR;
        endcase
    end

    assign state_o = state_q;

endmodule

// File: rtl/jtag_tap.sv
// rtl/jtag_tap.sv - JTAG TAP: instruction register, DR muxing, boundary-scan controls
// Optional feature macro: JTAG_IDCODE_EN (ID register present, reset
// instruction IDCODE); without it opcode 2 is BYPASS and reset is BYPASS.
// Ports:
//   tck, trst_n        test clock, async active-low reset
//   tms_i, tdi_i       TAP inputs
//   tdo_o, tdo_en_o    TAP output and its enable (Shift-DR/IR only)
//   bsc_scan_o/_i      head/tail of the boundary chain
//   bsc_shift_o, bsc_capture_o, bsc_update_o, bsc_mode_o   chain controls
//   ir_o               current instruction
module jtag_tap
    import jtag_pkg::*;
#(
    parameter int unsigned IR_W   = 4,
    parameter logic [31:0] IDCODE = 32'h1000_0001
) (
    input  logic            tck,
    input  logic            trst_n,
    input  logic            tms_i,
    input  logic            tdi_i,
    output logic            tdo_o,
    output logic            tdo_en_o,
    output logic            bsc_scan_o,
    input  logic            bsc_scan_i,
    output logic            bsc_shift_o,
    output logic            bsc_capture_o,
    output logic            bsc_update_o,
    output logic            bsc_mode_o,
    output logic [IR_W-1:0] ir_o
);

    localparam logic [IR_W-1:0] IR_EXTEST  = '0;
    localparam logic [IR_W-1:0] IR_BYPASS  = '1;
    localparam logic [IR_W-1:0] IR_SAMPLE  = IR_W'(OP_SAMPLE);
    localparam logic [IR_W-1:0] IR_IDCODE  = IR_W'(OP_IDCODE);
    localparam logic [IR_W-1:0] IR_CAPTURE = IR_W'(2'b01);
`ifdef JTAG_IDCODE_EN
    localparam logic [IR_W-1:0] IR_RESET   = IR_IDCODE;
`else
    localparam logic [IR_W-1:0] IR_RESET   = IR_BYPASS;
`endif

    tap_state_t state;

    jtag_tap_fsm u_fsm (
        .tck     (tck),
        .trst_n  (trst_n),
        .tms_i   (tms_i),
        .state_o (state)
    );

    logic [IR_W-1:0] ir_sh_q, ir_sh_d;
    logic [IR_W-1:0] ir_upd_q, ir_upd_d;
    logic [IR_W-1:0] ir_cur;
    logic            byp_q, byp_d;
    logic            sel_bsc, sel_id, sel_byp;
    logic            id_tdo;

    // Test-Logic-Reset forces the reset instruction immediately, so the
    // decode is already correct in the first TLR cycle, not one edge later.
    assign ir_cur  = (state == TAP_TLR) ? IR_RESET : ir_upd_q;
    assign sel_bsc = (ir_cur == IR_EXTEST) || (ir_cur == IR_SAMPLE);
    assign sel_byp = !sel_bsc && !sel_id;

    always_comb begin
        ir_sh_d = ir_sh_q;
        case (state)
            TAP_CAP_IR:   ir_sh_d = IR_CAPTURE;
            TAP_SHIFT_IR: ir_sh_d = {tdi_i, ir_sh_q[IR_W-1:1]};
            default:      ir_sh_d = ir_sh_q;
        endcase

        ir_upd_d = ir_upd_q;
        if (state == TAP_TLR) begin
            ir_upd_d = IR_RESET;
        end else if (state == TAP_UPD_IR) begin
            ir_upd_d = ir_sh_q;
        end

        byp_d = byp_q;
        if (sel_byp) begin
            if (state == TAP_CAP_DR) begin
                byp_d = 1'b0;
            end else if (state == TAP_SHIFT_DR) begin
                byp_d = tdi_i;
            end
        end
    end

    always_ff @(posedge tck or negedge trst_n) begin
        if (!trst_n) begin
            ir_sh_q  <= IR_CAPTURE;
            ir_upd_q <= IR_RESET;
            byp_q    <= 1'b0;
        end else begin
            ir_sh_q  <= ir_sh_d;
            ir_upd_q <= ir_upd_d;
            byp_q    <= byp_d;
        end
    end

`ifdef JTAG_IDCODE_EN
    logic [ID_W-1:0] idr_q, idr_d;

    assign sel_id = (ir_cur == IR_IDCODE);
    assign id_tdo = idr_q[0];

    always_comb begin
        idr_d = idr_q;
        if (sel_id) begin
            if (state == TAP_CAP_DR) begin
                idr_d = IDCODE;
            end else if (state == TAP_SHIFT_DR) begin
                idr_d = {tdi_i, idr_q[ID_W-1:1]};
            end
        end
    end

    always_ff @(posedge tck or negedge trst_n) begin
        if (!trst_n) begin
            idr_q <= '0;
        end else begin
            idr_q <= idr_d;
        end
    end
`else
    logic unused_idcode;

    assign sel_id        = 1'b0;
    assign id_tdo        = 1'b0;
    assign unused_idcode = ^{IDCODE, IR_IDCODE};
`endif

    // Cell ff_1 is only clocked while capture is high, so capture also
    // has to be asserted throughout Shift-DR.
    assign bsc_capture_o = sel_bsc && ((state == TAP_CAP_DR) || (state == TAP_SHIFT_DR));
    assign bsc_shift_o   = sel_bsc && (state == TAP_SHIFT_DR);
    assign bsc_update_o  = sel_bsc && (state == TAP_UPD_DR);
    assign bsc_mode_o    = (ir_cur == IR_EXTEST);
    assign bsc_scan_o    = tdi_i;
    assign ir_o          = ir_cur;

    always_comb begin
        tdo_o    = 1'b0;
        tdo_en_o = 1'b0;
        if (state == TAP_SHIFT_IR) begin
            tdo_o    = ir_sh_q[0];
            tdo_en_o = 1'b1;
        end else if (state == TAP_SHIFT_DR) begin
            tdo_en_o = 1'b1;
            if (sel_bsc) begin
                tdo_o = bsc_scan_i;
            end else if (sel_id) begin
                tdo_o = id_tdo;
            end else begin
                tdo_o = byp_q;
            end
        end
    end

endmodule

// File: tb/tb_jtag_tap.sv
// tb/tb_jtag_tap.sv - directed self-checking bench for jtag_tap with a 4-cell boundary chain
module tb_jtag_tap;

`ifdef JTAG_IDCODE_EN
    localparam logic [3:0] EXP_RST_IR = 4'h2;
`else
    localparam logic [3:0] EXP_RST_IR = 4'hF;
`endif

    logic       tck;
    logic       trst_n;
    logic       tms_i;
    logic       tdi_i;
    logic       tdo_o;
    logic       tdo_en_o;
    logic       bsc_scan_o;
    logic       bsc_shift_o;
    logic       bsc_capture_o;
    logic       bsc_update_o;
    logic       bsc_mode_o;
    logic [3:0] ir_o;

    // Boundary chain model: cell0 is nearest TDI, cell3 feeds TDO.
    logic [3:0] pins;
    logic [3:0] ff1;
    logic [3:0] ff2;
    logic [3:0] cell_out;

    int n_cmp;
    int n_bad;
    logic [31:0] d;
    logic [3:0]  cap;

    jtag_tap #(
        .IR_W   (4),
        .IDCODE (32'h1000_0001)
    ) dut (
        .tck           (tck),
        .trst_n        (trst_n),
        .tms_i         (tms_i),
        .tdi_i         (tdi_i),
        .tdo_o         (tdo_o),
        .tdo_en_o      (tdo_en_o),
        .bsc_scan_o    (bsc_scan_o),
        .bsc_scan_i    (ff1[3]),
        .bsc_shift_o   (bsc_shift_o),
        .bsc_capture_o (bsc_capture_o),
        .bsc_update_o  (bsc_update_o),
        .bsc_mode_o    (bsc_mode_o),
        .ir_o          (ir_o)
    );

    initial tck = 1'b0;
    always #5 tck = ~tck;

    always @(posedge tck) begin
        if (bsc_capture_o) ff1 <= bsc_shift_o ? {ff1[2:0], bsc_scan_o} : pins;
        if (bsc_update_o)  ff2 <= ff1;
    end
    assign cell_out = bsc_mode_o ? ff2 : pins;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic tms, input logic tdi);
        @(negedge tck);
        tms_i = tms;
        tdi_i = tdi;
        @(posedge tck);
        #1;
    endtask

    // RTI -> Shift-IR, shift val LSB first, stop in Update-IR.
    task automatic load_ir(input logic [3:0] val, output logic [3:0] cap_out);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cap_out[i] = tdo_o;
            tick(i == 3, val[i]);
        end
        tick(1'b1, 1'b0);
    endtask

    // RTI -> Shift-DR, shift n bits LSB first, stop in Exit1-DR.
    task automatic shift_dr(input logic [31:0] din, input int n, output logic [31:0] dout);
        dout = '0;
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        for (int i = 0; i < n; i++) begin
            dout[i] = tdo_o;
            tick(i == n - 1, din[i]);
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_bad  = 0;
        pins   = 4'b1010;
        ff1    = 4'b0000;
        ff2    = 4'b0000;
        tms_i  = 1'b1;
        tdi_i  = 1'b0;
        trst_n = 1'b1;
        #2 trst_n = 1'b0;
        #10;
        chk("rst_ir", 32'(ir_o), 32'(EXP_RST_IR));
        chk("rst_bsc", {28'd0, bsc_capture_o, bsc_shift_o, bsc_update_o, bsc_mode_o}, 32'd0);
        chk("rst_tdo", {30'd0, tdo_o, tdo_en_o}, 32'd0);

        @(negedge tck);
        trst_n = 1'b1;
        tick(1'b0, 1'b0);
        chk("rti_tdo_en", 32'(tdo_en_o), 32'd0);

        // Default instruction data register.
`ifdef JTAG_IDCODE_EN
        shift_dr(32'd0, 32, d);
        chk("idcode_shift", d, 32'h1000_0001);
`else
        shift_dr(32'b101, 3, d);
        chk("rst_bypass", 32'(d[2:0]), 32'b010);
`endif
        tick(1'b1, 1'b0);
        chk("nonbsc_update", 32'(bsc_update_o), 32'd0);
        tick(1'b0, 1'b0);

        // BYPASS: capture value on IR, one-bit delay on DR.
        load_ir(4'hF, cap);
        chk("ir_capture", 32'(cap), 32'b0001);
        tick(1'b0, 1'b0);
        chk("ir_bypass", 32'(ir_o), 32'hF);
        shift_dr(32'b101, 3, d);
        chk("bypass_101", 32'(d[2:0]), 32'b010);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);

        // Opcode 2: IDCODE when present, otherwise BYPASS.
        load_ir(4'h2, cap);
        tick(1'b0, 1'b0);
        chk("ir_op2", 32'(ir_o), 32'h2);
        shift_dr(32'b0110, 4, d);
`ifdef JTAG_IDCODE_EN
        chk("op2_dr", 32'(d[3:0]), 32'b0001);
`else
        chk("op2_dr", 32'(d[3:0]), 32'b1100);
`endif
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);

        // SAMPLE: capture pins, shift them out, Pause holds.
        load_ir(4'h1, cap);
        tick(1'b0, 1'b0);
        chk("sample_mode", 32'(bsc_mode_o), 32'd0);
        tick(1'b1, 1'b0);
        chk("seldr_capture", 32'(bsc_capture_o), 32'd0);
        tick(1'b0, 1'b0);
        chk("capdr_ctl", {30'd0, bsc_capture_o, bsc_shift_o}, 32'b10);
        tick(1'b0, 1'b0);
        chk("shdr_ctl", {30'd0, bsc_capture_o, bsc_shift_o}, 32'b11);
        chk("sample_first_tdo", 32'(tdo_o), 32'd1);
        d = '0;
        for (int i = 0; i < 4; i++) begin
            d[i] = tdo_o;
            tick(i == 3, 1'b0);
        end
        chk("sample_tdo", 32'(d[3:0]), 32'b0101);
        tick(1'b0, 1'b0);
        chk("pause_ctl", {29'd0, bsc_capture_o, bsc_shift_o, tdo_en_o}, 32'd0);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        chk("sample_update", 32'(bsc_update_o), 32'd1);
        tick(1'b0, 1'b0);
        chk("sample_update_end", 32'(bsc_update_o), 32'd0);

        // EXTEST: mode switches on the edge leaving Update-IR.
        load_ir(4'h0, cap);
        chk("updir_mode_old", 32'(bsc_mode_o), 32'd0);
        tick(1'b0, 1'b0);
        chk("extest_mode", 32'(bsc_mode_o), 32'd1);
        chk("extest_ir", 32'(ir_o), 32'd0);
        shift_dr(32'hC, 4, d);
        chk("extest_tdo", 32'(d[3:0]), 32'b0101);
        chk("extest_pre_update", 32'(cell_out), 32'b0000);
        tick(1'b1, 1'b0);
        chk("extest_update", 32'(bsc_update_o), 32'd1);
        tick(1'b0, 1'b0);
        chk("extest_update_end", 32'(bsc_update_o), 32'd0);
        chk("extest_cells", 32'(cell_out), 32'b0011);

        // trst_n during Shift-DR under EXTEST.
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        chk("trst_pre_shift", {30'd0, bsc_shift_o, bsc_mode_o}, 32'b11);
        tick(1'b0, 1'b1);
        @(negedge tck);
        trst_n = 1'b0;
        #1;
        chk("trst_bsc", {28'd0, bsc_capture_o, bsc_shift_o, bsc_update_o, bsc_mode_o}, 32'd0);
        chk("trst_tdo", {30'd0, tdo_o, tdo_en_o}, 32'd0);
        chk("trst_ir", 32'(ir_o), 32'(EXP_RST_IR));
        chk("trst_cells", 32'(cell_out), 32'b1010);
        @(negedge tck);
        trst_n = 1'b1;
        tick(1'b0, 1'b0);

        // Five TMS=1 from Shift-DR reach Test-Logic-Reset.
        load_ir(4'h0, cap);
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        chk("tms5_pre", {30'd0, tdo_en_o, bsc_mode_o}, 32'b11);
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b0);
        chk("tms5_ir", 32'(ir_o), 32'(EXP_RST_IR));
        chk("tms5_bsc", {28'd0, bsc_capture_o, bsc_shift_o, bsc_update_o, bsc_mode_o}, 32'd0);
        chk("tms5_tdo_en", 32'(tdo_en_o), 32'd0);
        tick(1'b0, 1'b0);
        chk("tms5_ir_held", 32'(ir_o), 32'(EXP_RST_IR));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
